control_unit: RTL and testbench

Hardwired control unit for the single-bus RISC CPU. It sequences fetch/execute by driving the register-select/encode stage (Gra/Grb/Grc/Rin/Rout/BAout), PC, MAR/MDR, Y/Z, HI/LO, ports and ALU operation from IR[31:27] and a step counter. It sits between IR/CON flip-flop and every datapath enable, and handshakes memory via `mem_ready`.

---
 rtl/cpu_ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_decode.sv | 136 +++++++++++++
 rtl/control_unit.sv | 108 ++++++++++
 tb/tb_control_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the hardwired control unit.
//   - 5-bit opcode constants (IR[31:27])
//   - 4-bit ALU operation constants
//   - step encoding (T0..T7 plus HALT)
//   - packed control word carried from the decoder to the top
//   - alu_for(): opcode -> ALU operation used in that opcode's ALU step
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd8
  } step_t;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, read, write, irin;
    logic yin, zin, zhighout, zlowout, hiin, loin, hiout, loout, cout;
    logic inportout, outportin, conin;
    logic [3:0] alu_op;
  } ctrl_word_t;

  localparam int CW_W = $bits(ctrl_word_t);

  // Address arithmetic (ld/ldi/st/br) and every unlisted opcode use ADD.
  function automatic logic [3:0] alu_for(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decode of (step, opcode, con, mem_ready)
// into the datapath control word plus sequencing hints for the step register.
//   step      in  4      current step (step_t encoding)
//   opcode    in  5      IR[31:27]
//   con       in  1      branch condition flip-flop
//   mem_ready in  1      memory has completed the current Read/Write
//   cw        out CW_W   packed ctrl_word_t
//   last_step out 1      this is the final step of the instruction
//   mem_wait  out 1      memory step still waiting: repeat this step
//   halt_req  out 1      halt instruction: leave to HALT instead of T0
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]      step,
  input  logic [4:0]      opcode,
  input  logic            con,
  input  logic            mem_ready,
  output logic [CW_W-1:0] cw,
  output logic            last_step,
  output logic            mem_wait,
  output logic            halt_req
);

  step_t      st;
  ctrl_word_t c;

  assign st = step_t'(step);
  assign cw = c;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of latches.
    c         = '0;
    last_step = 1'b0;
    mem_wait  = 1'b0;
    halt_req  = 1'b0;

    unique case (st)
      T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; end
      T1: begin
        c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1;
        mem_wait  = !mem_ready;
      end
      T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      HALT: ;
      default: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            // The three immediate-style forms differ only in T3 source and
            // T4 operand B (register vs. sign-extended constant).
            case (st)
              T3: begin
                c.grb = 1'b1; c.yin = 1'b1;
                if (opcode == OP_LDI) c.baout = 1'b1;
                else                  c.rout  = 1'b1;
              end
              T4: begin
                c.zin    = 1'b1;
                c.alu_op = alu_for(opcode);
                if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LDI}) c.cout = 1'b1;
                else begin c.grc = 1'b1; c.rout = 1'b1; end
              end
              T5: begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_LD, OP_ST: begin
            case (st)
              T3: begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
              T4: begin c.cout = 1'b1; c.zin = 1'b1; c.alu_op = ALU_ADD; end
              T5: begin c.zlowout = 1'b1; c.marin = 1'b1; end
              T6: begin
                c.mdrin = 1'b1;
                if (opcode == OP_LD) begin c.read = 1'b1; mem_wait = !mem_ready; end
                else begin c.gra = 1'b1; c.rout = 1'b1; end
              end
              T7: begin
                last_step = 1'b1;
                if (opcode == OP_LD) begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                else begin c.write = 1'b1; mem_wait = !mem_ready; end
              end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (st)
              T3: begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
              T4: begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.alu_op = alu_for(opcode); end
              T5: begin c.zlowout = 1'b1; c.loin = 1'b1; end
              T6: begin c.zhighout = 1'b1; c.hiin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (st)
              T3: begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.alu_op = alu_for(opcode); end
              T4: begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (st)
              T3: begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
              T4: begin c.pcout = 1'b1; c.yin = 1'b1; end
              T5: begin c.cout = 1'b1; c.zin = 1'b1; c.alu_op = ALU_ADD; end
              T6: begin
                last_step = 1'b1;
                // Untaken branch spends T6 idle so both outcomes take 7 cycles.
                if (con) begin c.zlowout = 1'b1; c.pcin = 1'b1; end
              end
              default: ;
            endcase
          end
          OP_JAL: begin
            case (st)
              T3: begin c.pcout = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
              T4: begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; last_step = 1'b1; end
              default: ;
            endcase
          end
          OP_JR:   if (st == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; last_step = 1'b1; end
          OP_IN:   if (st == T3) begin c.gra = 1'b1; c.rin = 1'b1; c.inportout = 1'b1; last_step = 1'b1; end
          OP_OUT:  if (st == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; last_step = 1'b1; end
          OP_MFHI: if (st == T3) begin c.gra = 1'b1; c.rin = 1'b1; c.hiout = 1'b1; last_step = 1'b1; end
          OP_MFLO: if (st == T3) begin c.gra = 1'b1; c.rin = 1'b1; c.loout = 1'b1; last_step = 1'b1; end
          OP_HALT: if (st == T3) begin halt_req = 1'b1; last_step = 1'b1; end
          OP_NOP:  if (st == T3) last_step = 1'b1;
          // Opcodes 27..31 are reserved and behave as nop.
          default: if (st == T3) last_step = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for the single-bus RISC CPU.
// Holds the step register (T0..T7, HALT); all strobes are decoded
// combinationally by ctrl_decode from the current step and IR[31:27].
//   clock, reset_n            clock (rising edge), async active-low reset
//   IR[31:0], CON             instruction register, branch condition
//   mem_ready                 memory completion for Read/Write steps
//   stop, start               halt at next instruction boundary / resume
//   Gra..BAout                register select/encode controls
//   PCout..IRin               PC, MAR/MDR, memory and IR controls
//   Yin..Cout                 Y/Z/HI/LO and constant controls
//   InPortout, OutPortin, CONin  port and CON flip-flop controls
//   alu_op[3:0]               ALU operation
//   run                       1 while executing, 0 in HALT
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  input  logic        stop,
  input  logic        start,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
  output logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout,
  output logic        InPortout, OutPortin, CONin,
  output logic [3:0]  alu_op,
  output logic        run
);

  step_t           step_q, step_nx;
  logic [CW_W-1:0] cw_bits;
  ctrl_word_t      cw, cw_o;
  logic            last_step, mem_wait, halt_req;
  logic            ir_unused;

  // Operand fields of IR are consumed by the select/encode stage, not here.
  assign ir_unused = ^IR[26:0];

  ctrl_decode u_decode (
    .step      (step_q),
    .opcode    (IR[31:27]),
    .con       (CON),
    .mem_ready (mem_ready),
    .cw        (cw_bits),
    .last_step (last_step),
    .mem_wait  (mem_wait),
    .halt_req  (halt_req)
  );

  always_comb begin
    step_nx = step_q;
    if (step_q == HALT) begin
      if (start) step_nx = T0;
    end else if (mem_wait) begin
      step_nx = step_q;
    end else if (last_step) begin
      step_nx = (halt_req || stop) ? HALT : T0;
    end else begin
      step_nx = step_t'(step_q + 4'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) step_q <= T0;
    else          step_q <= step_nx;
  end

  // NOTE: the step register resets to T0, whose decode is the fetch strobes;
  // masking with reset_n keeps every strobe low while reset is held and drops
  // any in-flight strobe (e.g. a waiting Write) in the same cycle reset falls.
  assign cw   = ctrl_word_t'(cw_bits);
  assign cw_o = reset_n ? cw : '0;
  assign run  = (step_q != HALT);

  assign Gra       = cw_o.gra;
  assign Grb       = cw_o.grb;
  assign Grc       = cw_o.grc;
  assign Rin       = cw_o.rin;
  assign Rout      = cw_o.rout;
  assign BAout     = cw_o.baout;
  assign PCout     = cw_o.pcout;
  assign PCin      = cw_o.pcin;
  assign IncPC     = cw_o.incpc;
  assign MARin     = cw_o.marin;
  assign MDRin     = cw_o.mdrin;
  assign MDRout    = cw_o.mdrout;
  assign Read      = cw_o.read;
  assign Write     = cw_o.write;
  assign IRin      = cw_o.irin;
  assign Yin       = cw_o.yin;
  assign Zin       = cw_o.zin;
  assign Zhighout  = cw_o.zhighout;
  assign Zlowout   = cw_o.zlowout;
  assign HIin      = cw_o.hiin;
  assign LOin      = cw_o.loin;
  assign HIout     = cw_o.hiout;
  assign LOout     = cw_o.loout;
  assign Cout      = cw_o.cout;
  assign InPortout = cw_o.inportout;
  assign OutPortin = cw_o.outportin;
  assign CONin     = cw_o.conin;
  assign alu_op    = cw_o.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: the stimulus process pushes the
// hand-derived expected control vector for every cycle it drives; a monitor
// pops one entry per falling clock edge and compares it with the DUT outputs.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] IR;
  logic        CON, mem_ready, stop, start;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
  logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout;
  logic        InPortout, OutPortin, CONin;
  logic [3:0]  alu_op;
  logic        run;

  control_unit dut (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON(CON), .mem_ready(mem_ready),
    .stop(stop), .start(start),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin),
    .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin),
    .alu_op(alu_op), .run(run)
  );

  always #5 clock = ~clock;

  // Bench-side bit layout of the observed vector: {run, alu_op, 27 strobes}.
  localparam logic [31:0] M_GRA  = 32'd1 << 0,  M_GRB  = 32'd1 << 1,  M_GRC   = 32'd1 << 2;
  localparam logic [31:0] M_RIN  = 32'd1 << 3,  M_ROUT = 32'd1 << 4,  M_BAOUT = 32'd1 << 5;
  localparam logic [31:0] M_PCOUT = 32'd1 << 6, M_PCIN = 32'd1 << 7,  M_INCPC = 32'd1 << 8;
  localparam logic [31:0] M_MARIN = 32'd1 << 9, M_MDRIN = 32'd1 << 10, M_MDROUT = 32'd1 << 11;
  localparam logic [31:0] M_READ = 32'd1 << 12, M_WRITE = 32'd1 << 13, M_IRIN = 32'd1 << 14;
  localparam logic [31:0] M_YIN  = 32'd1 << 15, M_ZIN  = 32'd1 << 16, M_ZHI   = 32'd1 << 17;
  localparam logic [31:0] M_ZLO  = 32'd1 << 18, M_HIIN = 32'd1 << 19, M_LOIN  = 32'd1 << 20;
  localparam logic [31:0] M_HIOUT = 32'd1 << 21, M_LOOUT = 32'd1 << 22, M_COUT = 32'd1 << 23;
  localparam logic [31:0] M_INP  = 32'd1 << 24, M_OUTP = 32'd1 << 25, M_CONIN = 32'd1 << 26;
  localparam logic [31:0] M_RUN  = 32'd1 << 31;

  typedef struct {
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] got;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] ex(input logic [31:0] m, input logic [3:0] a);
    return M_RUN | m | ({28'd0, a} << 27);
  endfunction

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (q.size() != 0) begin
      e   = q.pop_front();
      got = {run, alu_op, CONin, OutPortin, InPortout, Cout, LOout, HIout, LOin, HIin,
             Zlowout, Zhighout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
             IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};
      n_cmp++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", e.name, got, e.v, $time);
      end
    end
  end

  task automatic cyc(input logic [31:0] v, input string n);
    exp_t t;
    t.v = v;
    t.name = n;
    q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  task automatic x(input logic [31:0] m, input logic [3:0] a, input string n);
    cyc(ex(m, a), n);
  endtask

  // Fetch with mem_ready low outside T1 (must be ignored) and `waits` wait
  // cycles in T1.
  task automatic fetch(input logic [4:0] op, input int waits, input string n);
    IR = {op, 27'h05a1234};
    mem_ready = 1'b0;
    x(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, {n, " T0"});
    for (int k = 0; k < waits; k++) x(M_ZLO | M_PCIN | M_READ | M_MDRIN, 4'd0, {n, " T1 wait"});
    mem_ready = 1'b1;
    x(M_ZLO | M_PCIN | M_READ | M_MDRIN, 4'd0, {n, " T1"});
    mem_ready = 1'b0;
    x(M_MDROUT | M_IRIN, 4'd0, {n, " T2"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; IR = {5'd3, 27'd0}; CON = 1'b0;
    mem_ready = 1'b1; stop = 1'b0; start = 1'b0;
    @(posedge clock);
    #1;
    cyc(M_RUN, "reset held");
    cyc(M_RUN, "reset held 2");
    reset_n = 1'b1;

    // add; stop/start asserted in a non-final step must be ignored
    fetch(5'd3, 0, "add");
    stop = 1'b1; start = 1'b1;
    x(M_GRB | M_ROUT | M_YIN, 4'd0, "add T3");
    stop = 1'b0; start = 1'b0;
    x(M_GRC | M_ROUT | M_ZIN, 4'd0, "add T4");
    x(M_ZLO | M_GRA | M_RIN, 4'd0, "add T5");

    // ld with three wait cycles in T6: MDRout/Gra/Rin at cycle 11
    fetch(5'd0, 0, "ld");
    x(M_GRB | M_BAOUT | M_YIN, 4'd0, "ld T3");
    x(M_COUT | M_ZIN, 4'd0, "ld T4");
    x(M_ZLO | M_MARIN, 4'd0, "ld T5");
    for (int k = 0; k < 3; k++) x(M_READ | M_MDRIN, 4'd0, "ld T6 wait");
    mem_ready = 1'b1;
    x(M_READ | M_MDRIN, 4'd0, "ld T6");
    mem_ready = 1'b0;
    x(M_MDROUT | M_GRA | M_RIN, 4'd0, "ld T7");

    // br not taken, then taken
    CON = 1'b0;
    fetch(5'd18, 0, "br0");
    x(M_GRA | M_ROUT | M_CONIN, 4'd0, "br0 T3");
    x(M_PCOUT | M_YIN, 4'd0, "br0 T4");
    x(M_COUT | M_ZIN, 4'd0, "br0 T5");
    x(32'd0, 4'd0, "br0 T6 idle");
    CON = 1'b1;
    fetch(5'd18, 0, "br1");
    x(M_GRA | M_ROUT | M_CONIN, 4'd0, "br1 T3");
    x(M_PCOUT | M_YIN, 4'd0, "br1 T4");
    x(M_COUT | M_ZIN, 4'd0, "br1 T5");
    x(M_ZLO | M_PCIN, 4'd0, "br1 T6 taken");

    // mul
    fetch(5'd14, 0, "mul");
    x(M_GRA | M_ROUT | M_YIN, 4'd0, "mul T3");
    x(M_GRB | M_ROUT | M_ZIN, 4'd8, "mul T4");
    x(M_ZLO | M_LOIN, 4'd0, "mul T5");
    x(M_ZHI | M_HIIN, 4'd0, "mul T6");

    // ori, ldi, neg, jal, mfhi, reserved opcode 29
    fetch(5'd13, 0, "ori");
    x(M_GRB | M_ROUT | M_YIN, 4'd0, "ori T3");
    x(M_COUT | M_ZIN, 4'd3, "ori T4");
    x(M_ZLO | M_GRA | M_RIN, 4'd0, "ori T5");
    fetch(5'd1, 0, "ldi");
    x(M_GRB | M_BAOUT | M_YIN, 4'd0, "ldi T3");
    x(M_COUT | M_ZIN, 4'd0, "ldi T4");
    x(M_ZLO | M_GRA | M_RIN, 4'd0, "ldi T5");
    fetch(5'd16, 0, "neg");
    x(M_GRB | M_ROUT | M_ZIN, 4'd10, "neg T3");
    x(M_ZLO | M_GRA | M_RIN, 4'd0, "neg T4");
    fetch(5'd20, 0, "jal");
    x(M_PCOUT | M_GRB | M_RIN, 4'd0, "jal T3");
    x(M_GRA | M_ROUT | M_PCIN, 4'd0, "jal T4");
    fetch(5'd23, 0, "mfhi");
    x(M_GRA | M_RIN | M_HIOUT, 4'd0, "mfhi T3");
    fetch(5'd29, 0, "op29");
    x(32'd0, 4'd0, "op29 T3 as nop");

    // nop with stop in its last step -> HALT; start resumes
    fetch(5'd25, 0, "nop");
    stop = 1'b1;
    x(32'd0, 4'd0, "nop T3 stop");
    stop = 1'b0;
    cyc(32'd0, "halt after stop");
    cyc(32'd0, "halt after stop 2");
    start = 1'b1;
    cyc(32'd0, "halt start cycle");
    start = 1'b0;

    // st with a T1 wait, T7 wait, then async reset mid-wait
    fetch(5'd2, 1, "st");
    x(M_GRB | M_BAOUT | M_YIN, 4'd0, "st T3");
    x(M_COUT | M_ZIN, 4'd0, "st T4");
    x(M_ZLO | M_MARIN, 4'd0, "st T5");
    x(M_GRA | M_ROUT | M_MDRIN, 4'd0, "st T6");
    x(M_WRITE, 4'd0, "st T7 wait");
    x(M_WRITE, 4'd0, "st T7 wait 2");
    reset_n = 1'b0;
    cyc(M_RUN, "reset mid-wait");
    reset_n = 1'b1;

    // st completing with stop high in T7 -> HALT
    fetch(5'd2, 0, "st2");
    x(M_GRB | M_BAOUT | M_YIN, 4'd0, "st2 T3");
    x(M_COUT | M_ZIN, 4'd0, "st2 T4");
    x(M_ZLO | M_MARIN, 4'd0, "st2 T5");
    x(M_GRA | M_ROUT | M_MDRIN, 4'd0, "st2 T6");
    mem_ready = 1'b1; stop = 1'b1;
    x(M_WRITE, 4'd0, "st2 T7 stop");
    mem_ready = 1'b0; stop = 1'b0;
    cyc(32'd0, "halt after st2");
    start = 1'b1;
    cyc(32'd0, "halt start 2");
    start = 1'b0;

    // halt opcode: ten idle HALT cycles, then start
    fetch(5'd26, 0, "halt");
    x(32'd0, 4'd0, "halt T3");
    for (int k = 0; k < 10; k++) cyc(32'd0, "halt idle");
    start = 1'b1;
    cyc(32'd0, "halt start 3");
    start = 1'b0;

    // jr, in, out
    fetch(5'd19, 0, "jr");
    x(M_GRA | M_ROUT | M_PCIN, 4'd0, "jr T3");
    fetch(5'd21, 0, "in");
    x(M_GRA | M_RIN | M_INP, 4'd0, "in T3");
    fetch(5'd22, 0, "out");
    x(M_GRA | M_ROUT | M_OUTP, 4'd0, "out T3");
    x(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, "final T0");

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
